// File: rtl/cache_pkg.sv
// Shared constants for the cache memory-port arbiter slice.
// Read FSM encodings, request types and line geometry.
package cache_pkg;

  localparam logic [2:0] R_IDLE = 3'b001;
  localparam logic [2:0] R_REQ  = 3'b010;
  localparam logic [2:0] R_RET  = 3'b100;

  localparam logic [2:0] RD_LINE = 3'b100;
  localparam logic [2:0] RD_WORD = 3'b010;

  localparam int LINE_OFF = 4;

  function automatic logic same_line(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a[31:LINE_OFF] == b[31:LINE_OFF];
  endfunction

endpackage

// File: rtl/cache_wr_buffer.sv
// One-entry dcache writeback buffer with drain handshake
// and same-line hazard detection for both read clients.
module cache_wr_buffer
  import cache_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr_req,
  input  logic [2:0]   i_wr_type,
  input  logic [31:0]  i_wr_addr,
  input  logic [127:0] i_wr_data,
  input  logic         i_m_wr_rdy,
  input  logic [31:0]  i_ic_addr,
  input  logic [31:0]  i_dc_addr,
  output logic         o_wr_rdy,
  output logic         o_m_wr_req,
  output logic [2:0]   o_m_wr_type,
  output logic [31:0]  o_m_wr_addr,
  output logic [127:0] o_m_wr_data,
  output logic         o_ic_hit,
  output logic         o_dc_hit
);

  logic         r_valid;
  logic [2:0]   r_type;
  logic [31:0]  r_addr;
  logic [127:0] r_data;
  logic         w_accept;
  logic         w_drain;

  // accept needs empty, drain needs full: never both at once
  assign w_accept = i_wr_req & ~r_valid;
  assign w_drain  = r_valid & i_m_wr_rdy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_type  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_type  <= i_wr_type;
      r_addr  <= i_wr_addr;
      r_data  <= i_wr_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_wr_rdy    = ~r_valid;
  assign o_m_wr_req  = r_valid;
  assign o_m_wr_type = r_type;
  assign o_m_wr_addr = r_addr;
  assign o_m_wr_data = r_data;
  assign o_ic_hit    = r_valid & same_line(i_ic_addr, r_addr);
  assign o_dc_hit    = r_valid & same_line(i_dc_addr, r_addr);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cache-side memory port between icache and dcache:
// round-robin reads with one outstanding fill, buffered writebacks.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic [1:0]   ic_ret_last,
  output logic [31:0]  ic_ret_data,
  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic [1:0]   dc_ret_last,
  output logic [31:0]  dc_ret_data,
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  output logic         m_rd_req,
  output logic [2:0]   m_rd_type,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  input  logic         m_ret_valid,
  input  logic [1:0]   m_ret_last,
  input  logic [31:0]  m_ret_data,
  output logic         m_wr_req,
  output logic [2:0]   m_wr_type,
  output logic [31:0]  m_wr_addr,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy
);

  logic [2:0]  r_state;
  logic        r_owner_dc;
  logic        r_last_dc;
  logic [2:0]  r_type;
  logic [31:0] r_addr;
  logic        w_ic_hit;
  logic        w_dc_hit;
  logic        w_ic_el;
  logic        w_dc_el;
  logic        w_pick_dc;
  logic        w_in_req;
  logic        w_in_ret;
  logic        w_last;

  cache_wr_buffer u_wbuf (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_wr_req    (dc_wr_req),
    .i_wr_type   (dc_wr_type),
    .i_wr_addr   (dc_wr_addr),
    .i_wr_data   (dc_wr_data),
    .i_m_wr_rdy  (m_wr_rdy),
    .i_ic_addr   (ic_rd_addr),
    .i_dc_addr   (dc_rd_addr),
    .o_wr_rdy    (dc_wr_rdy),
    .o_m_wr_req  (m_wr_req),
    .o_m_wr_type (m_wr_type),
    .o_m_wr_addr (m_wr_addr),
    .o_m_wr_data (m_wr_data),
    .o_ic_hit    (w_ic_hit),
    .o_dc_hit    (w_dc_hit)
  );

  assign w_ic_el = ic_rd_req & ~w_ic_hit;
  assign w_dc_el = dc_rd_req & ~w_dc_hit;

  // r_last_dc=0 after reset, so the dcache wins the first tie
  assign w_pick_dc = w_dc_el &
    (~w_ic_el | (RR_EN == 0) | ~r_last_dc);

  assign w_in_req = r_state[1];
  assign w_in_ret = r_state[2];
  assign w_last   = m_ret_last[0] | (m_ret_last[1] & 1'b0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      r_owner_dc <= 1'b0;
      r_last_dc  <= 1'b0;
      r_type     <= '0;
      r_addr     <= '0;
    end else begin
      unique case (1'b1)
        r_state[0]: begin
          if (w_ic_el | w_dc_el) begin
            r_state    <= R_REQ;
            r_owner_dc <= w_pick_dc;
            r_last_dc  <= w_pick_dc;
            r_type     <= w_pick_dc ? dc_rd_type : ic_rd_type;
            r_addr     <= w_pick_dc ? dc_rd_addr : ic_rd_addr;
          end
        end
        r_state[1]: begin
          if (m_rd_rdy) r_state <= R_RET;
        end
        r_state[2]: begin
          if (m_ret_valid & w_last) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign m_rd_req  = w_in_req;
  assign m_rd_type = r_type;
  assign m_rd_addr = r_addr;

  assign ic_rd_rdy = w_in_req & m_rd_rdy & ~r_owner_dc;
  assign dc_rd_rdy = w_in_req & m_rd_rdy &  r_owner_dc;

  assign ic_ret_valid = w_in_ret & ~r_owner_dc & m_ret_valid;
  assign dc_ret_valid = w_in_ret &  r_owner_dc & m_ret_valid;
  assign ic_ret_last  = {1'b0, w_in_ret & ~r_owner_dc & w_last};
  assign dc_ret_last  = {1'b0, w_in_ret &  r_owner_dc & w_last};
  assign ic_ret_data  = m_ret_data;
  assign dc_ret_data  = m_ret_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reads, arbitration,
// write buffer, hazard blocking and mid-return reset.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_rd_req, dc_rd_req;
  logic [2:0]   ic_rd_type, dc_rd_type;
  logic [31:0]  ic_rd_addr, dc_rd_addr;
  logic         dc_wr_req;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [127:0] dc_wr_data;
  logic         m_rd_rdy, m_ret_valid, m_wr_rdy;
  logic [1:0]   m_ret_last;
  logic [31:0]  m_ret_data;

  logic         ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid;
  logic [1:0]   ic_ret_last, dc_ret_last;
  logic [31:0]  ic_ret_data, dc_ret_data;
  logic         dc_wr_rdy, m_rd_req, m_wr_req;
  logic [2:0]   m_rd_type, m_wr_type;
  logic [31:0]  m_rd_addr, m_wr_addr;
  logic [127:0] m_wr_data;

  logic         f_ic_rd_rdy, f_dc_rd_rdy, f_ic_ret_valid, f_dc_ret_valid;
  logic [1:0]   f_ic_ret_last, f_dc_ret_last;
  logic [31:0]  f_ic_ret_data, f_dc_ret_data;
  logic         f_dc_wr_rdy, f_m_rd_req, f_m_wr_req;
  logic [2:0]   f_m_rd_type, f_m_wr_type;
  logic [31:0]  f_m_rd_addr, f_m_wr_addr;
  logic [127:0] f_m_wr_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type),
    .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type),
    .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
    .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type),
    .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(dc_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type),
    .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_rdy(m_wr_rdy)
  );

  cache_mem_arbiter #(.RR_EN(0)) dut_fix (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type),
    .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(f_ic_rd_rdy),
    .ic_ret_valid(f_ic_ret_valid), .ic_ret_last(f_ic_ret_last),
    .ic_ret_data(f_ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type),
    .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(f_dc_rd_rdy),
    .dc_ret_valid(f_dc_ret_valid), .dc_ret_last(f_dc_ret_last),
    .dc_ret_data(f_dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type),
    .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(f_dc_wr_rdy),
    .m_rd_req(f_m_rd_req), .m_rd_type(f_m_rd_type),
    .m_rd_addr(f_m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
    .m_ret_data(m_ret_data),
    .m_wr_req(f_m_wr_req), .m_wr_type(f_m_wr_type),
    .m_wr_addr(f_m_wr_addr), .m_wr_data(f_m_wr_data),
    .m_wr_rdy(m_wr_rdy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs;
    ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0;
    dc_wr_data = 0;
    m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0;
    m_ret_data = 0; m_wr_rdy = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // wait for a grant pulse, then return a single last beat
  task automatic get_grant(input bit fixed, output logic is_dc);
    bit found = 0;
    logic gi, gd;
    is_dc = 1'bx;
    for (int c = 0; c < 10 && !found; c++) begin
      gi = fixed ? f_ic_rd_rdy : ic_rd_rdy;
      gd = fixed ? f_dc_rd_rdy : dc_rd_rdy;
      if (gi | gd) begin
        found = 1;
        is_dc = gd;
      end
      step();
    end
    if (!found) chk("grant_timeout", 0, 1);
    m_ret_valid = 1; m_ret_last = 2'b01;
    step();
    m_ret_valid = 0; m_ret_last = 2'b00;
  endtask

  logic g;
  logic [127:0] l1, l2;

  initial begin
    reset = 1'b1;
    clear_inputs();
    m_ret_valid = 1;
    #2;
    chk("rst_m_rd_req", m_rd_req, 0);
    chk("rst_m_wr_req", m_wr_req, 0);
    chk("rst_dc_wr_rdy", dc_wr_rdy, 1);
    chk("rst_ic_rd_rdy", ic_rd_rdy, 0);
    chk("rst_dc_rd_rdy", dc_rd_rdy, 0);
    chk("rst_ic_ret_valid", ic_ret_valid, 0);
    chk("rst_dc_ret_valid", dc_ret_valid, 0);
    chk("rst_m_rd_addr", m_rd_addr, 0);
    chk("rst_m_wr_data", m_wr_data, 0);

    // single icache line fill
    do_reset();
    m_rd_rdy = 1;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0010;
    chk("ic_no_req_yet", m_rd_req, 0);
    step();
    chk("ic_m_rd_req", m_rd_req, 1);
    chk("ic_rd_rdy", ic_rd_rdy, 1);
    chk("ic_dc_rd_rdy", dc_rd_rdy, 0);
    chk("ic_m_rd_addr", m_rd_addr, 32'h1C00_0010);
    chk("ic_m_rd_type", m_rd_type, 3'b100);
    ic_rd_req = 0;
    step();
    chk("ic_rdy_pulse", ic_rd_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      m_ret_valid = 1;
      m_ret_data = 32'hA0 + i;
      m_ret_last = (i == 3) ? 2'b01 : 2'b00;
      #1;
      chk("ic_ret_valid", ic_ret_valid, 1);
      chk("ic_ret_data", ic_ret_data, 32'hA0 + i);
      chk("ic_ret_last", ic_ret_last, (i == 3) ? 2'b01 : 2'b00);
      chk("ic_dc_ret_valid", dc_ret_valid, 0);
      step();
    end
    m_ret_valid = 0; m_ret_last = 0;
    chk("ic_back_idle", m_rd_req, 0);

    // round-robin: dc, ic, dc, ic
    do_reset();
    m_rd_rdy = 1;
    ic_rd_req = 1; ic_rd_addr = 32'h0000_1000;
    dc_rd_req = 1; dc_rd_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      get_grant(0, g);
      chk("rr_grant_dc", g, (k % 2 == 0) ? 1'b1 : 1'b0);
    end

    // fixed priority: dc every time
    do_reset();
    m_rd_rdy = 1;
    ic_rd_req = 1; ic_rd_addr = 32'h0000_1000;
    dc_rd_req = 1; dc_rd_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      get_grant(1, g);
      chk("fix_grant_dc", g, 1'b1);
    end

    // hazard: dc read to buffered line waits for drain
    do_reset();
    m_rd_rdy = 1;
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230;
    dc_wr_data = 128'hDEAD_BEEF;
    step();
    dc_wr_req = 0;
    chk("hz_m_wr_req", m_wr_req, 1);
    chk("hz_dc_wr_rdy", dc_wr_rdy, 0);
    chk("hz_m_wr_addr", m_wr_addr, 32'h0000_1230);
    dc_rd_req = 1; dc_rd_addr = 32'h0000_1234;
    step();
    chk("hz_blocked1", m_rd_req, 0);
    ic_rd_req = 1; ic_rd_addr = 32'h0000_2000;
    step();
    chk("hz_ic_granted", ic_rd_rdy, 1);
    chk("hz_ic_addr", m_rd_addr, 32'h0000_2000);
    ic_rd_req = 0;
    step();
    m_ret_valid = 1; m_ret_last = 2'b01;
    step();
    m_ret_valid = 0; m_ret_last = 0;
    chk("hz_blocked2", m_rd_req, 0);
    chk("hz_still_full", m_wr_req, 1);
    m_wr_rdy = 1;
    step();
    m_wr_rdy = 0;
    chk("hz_blocked3", m_rd_req, 0);
    chk("hz_drained", m_wr_req, 0);
    chk("hz_wr_rdy", dc_wr_rdy, 1);
    step();
    chk("hz_dc_granted", dc_rd_rdy, 1);
    chk("hz_dc_addr", m_rd_addr, 32'h0000_1234);
    dc_rd_req = 0;
    step();
    m_ret_valid = 1; m_ret_last = 2'b01;
    step();
    m_ret_valid = 0; m_ret_last = 0;

    // back-to-back writebacks
    do_reset();
    l1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    l2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    dc_wr_req = 1; dc_wr_type = 3'b100;
    dc_wr_addr = 32'h0000_0100; dc_wr_data = l1;
    step();
    chk("bb_full_rdy", dc_wr_rdy, 0);
    chk("bb_data1", m_wr_data, l1);
    dc_wr_addr = 32'h0000_0200; dc_wr_data = l2;
    step();
    chk("bb_hold_data1", m_wr_data, l1);
    chk("bb_hold_addr1", m_wr_addr, 32'h0000_0100);
    m_wr_rdy = 1;
    step();
    m_wr_rdy = 0;
    chk("bb_empty", m_wr_req, 0);
    chk("bb_rdy_again", dc_wr_rdy, 1);
    step();
    dc_wr_req = 0;
    chk("bb_req2", m_wr_req, 1);
    chk("bb_data2", m_wr_data, l2);
    chk("bb_addr2", m_wr_addr, 32'h0000_0200);
    m_wr_rdy = 1;
    step();
    m_wr_rdy = 0;
    chk("bb_drain2", m_wr_req, 0);

    // reset in the middle of a return burst
    do_reset();
    m_rd_rdy = 1;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0010;
    step();
    ic_rd_req = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      m_ret_valid = 1; m_ret_data = 32'hB0 + i; m_ret_last = 0;
      step();
    end
    m_ret_data = 32'hB2;
    #1;
    chk("mr_pre_valid", ic_ret_valid, 1);
    reset = 1;
    #1;
    chk("mr_ic_valid0", ic_ret_valid, 0);
    chk("mr_dc_valid0", dc_ret_valid, 0);
    step();
    reset = 0;
    for (int i = 2; i < 4; i++) begin
      m_ret_valid = 1; m_ret_data = 32'hB0 + i;
      m_ret_last = (i == 3) ? 2'b01 : 2'b00;
      #1;
      chk("mr_ic_drop", ic_ret_valid, 0);
      chk("mr_dc_drop", dc_ret_valid, 0);
      step();
    end
    m_ret_valid = 0; m_ret_last = 0;
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_0040;
    step();
    chk("mr_dc_granted", dc_rd_rdy, 1);
    chk("mr_dc_addr", m_rd_addr, 32'h0000_0040);
    dc_rd_req = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
